// File: rtl/ni_packet_tx_if.sv
// Bundle for the network-interface transmit port: packet requests and
// payload words from the PE side, flits plus RTS/CTS to the router's local port.
interface ni_packet_tx_if #(
  parameter int DATA_WIDTH = 32,
  parameter int AXIS       = 4
);

  // Packet request from the PE
  logic                  req_valid;
  logic [AXIS-1:0]       req_dst;
  logic [11:0]           req_len;
  logic                  req_ready;

  // Payload word stream from the PE
  logic                  pl_valid;
  logic [DATA_WIDTH-5:0] pl_data;
  logic                  pl_ready;

  // Flit channel into the router's local input FIFO
  logic [DATA_WIDTH-1:0] TX;
  logic                  RTS;
  logic                  DCTS;

  // Producer of requests/payload and consumer of flits (PE plus router side)
  modport master (
    output req_valid, req_dst, req_len,
    input  req_ready,
    output pl_valid, pl_data,
    input  pl_ready,
    input  TX, RTS,
    output DCTS
  );

  // The transmit engine itself
  modport slave (
    input  req_valid, req_dst, req_len,
    output req_ready,
    input  pl_valid, pl_data,
    output pl_ready,
    output TX, RTS,
    input  DCTS
  );

endinterface

// File: rtl/ni_packet_tx.sv
// Network-interface transmit engine. Takes a packet request and a stream of
// payload words, and emits header, body and tail flits (each carrying even
// parity in bit 0) into the router's local input using RTS/CTS flow control.
module ni_packet_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int AXIS       = 4,
  parameter int PID_W      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXIS-1:0]           cur_addr,
  ni_packet_tx_if.slave             bus,
  output logic                      busy,
  output logic                      len_err
);

  localparam logic [2:0] TYPE_HDR  = 3'b001;
  localparam logic [2:0] TYPE_BODY = 3'b010;
  localparam logic [2:0] TYPE_TAIL = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_PAY,
    S_DRAIN
  } state_t;

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   tx_reg, tx_next;
  logic                    rts_reg, rts_next;
  logic [11:0]             rem_reg, rem_next;
  logic [11:0]             len_reg, len_next;
  logic [AXIS-1:0]         dst_reg, dst_next;
  logic [AXIS-1:0]         src_reg, src_next;
  logic [PID_W-1:0]        pid_reg, pid_next;
  logic                    len_err_reg, len_err_next;
  logic                    ready_reg;
  logic                    req_ready_c;
  logic                    pl_ready_c;
  logic                    ld;

  // Fill in bit 0 so the whole flit has even parity over the upper bits.
  function automatic logic [DATA_WIDTH-1:0] seal(input logic [DATA_WIDTH-1:0] f);
    logic [DATA_WIDTH-1:0] r;
    r    = f;
    r[0] = ^f[DATA_WIDTH-1:1];
    return r;
  endfunction

  // The output register may only change when nothing is offered or the
  // offered flit is being taken this cycle.
  assign ld = !rts_reg || bus.DCTS;

  // Stays low through reset and the first edge after it, so no request is
  // accepted before the engine has seen a clean clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_reg <= 1'b0;
    end else begin
      ready_reg <= 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      tx_reg      <= '0;
      rts_reg     <= 1'b0;
      rem_reg     <= '0;
      len_reg     <= '0;
      dst_reg     <= '0;
      src_reg     <= '0;
      pid_reg     <= '0;
      len_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tx_reg      <= tx_next;
      rts_reg     <= rts_next;
      rem_reg     <= rem_next;
      len_reg     <= len_next;
      dst_reg     <= dst_next;
      src_reg     <= src_next;
      pid_reg     <= pid_next;
      len_err_reg <= len_err_next;
    end
  end

  // Next-state, flit construction and handshake outputs.
  always_comb begin
    state_next   = state_reg;
    tx_next      = tx_reg;
    rts_next     = rts_reg;
    rem_next     = rem_reg;
    len_next     = len_reg;
    dst_next     = dst_reg;
    src_next     = src_reg;
    pid_next     = pid_reg;
    len_err_next = 1'b0;
    req_ready_c  = 1'b0;
    pl_ready_c   = 1'b0;

    unique case (state_reg)
      S_IDLE: begin
        req_ready_c = ready_reg;
        if (bus.req_valid && ready_reg) begin
          if (bus.req_len != 12'd0) begin
            len_next   = bus.req_len;
            dst_next   = bus.req_dst;
            src_next   = cur_addr;
            state_next = S_HDR;
          end else begin
            // Zero-length requests are consumed and flagged; nothing is sent.
            len_err_next = 1'b1;
          end
        end
      end

      S_HDR: begin
        if (ld) begin
          tx_next    = seal({TYPE_HDR, len_reg + 12'd1, dst_reg, src_reg, pid_reg, 1'b0});
          rts_next   = 1'b1;
          rem_next   = len_reg;
          state_next = S_PAY;
        end
      end

      S_PAY: begin
        pl_ready_c = ld;
        if (ld) begin
          if (bus.pl_valid) begin
            // The last remaining word becomes the tail; rem_reg is >= 1 here,
            // so the decrement cannot underflow.
            tx_next  = seal({(rem_reg == 12'd1) ? TYPE_TAIL : TYPE_BODY, bus.pl_data, 1'b0});
            rts_next = 1'b1;
            rem_next = rem_reg - 12'd1;
            if (rem_reg == 12'd1) begin
              state_next = S_DRAIN;
            end
          end else begin
            // No word available: offer a bubble rather than repeat a flit.
            rts_next = 1'b0;
          end
        end
      end

      S_DRAIN: begin
        if (ld) begin
          rts_next   = 1'b0;
          pid_next   = pid_reg + 1'b1;
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign bus.req_ready = req_ready_c;
  assign bus.pl_ready  = pl_ready_c;
  assign bus.TX        = tx_reg;
  assign bus.RTS       = rts_reg;
  assign busy          = (state_reg != S_IDLE);
  assign len_err       = len_err_reg;

endmodule

// File: tb/tb_ni_packet_tx.sv
// Bench for ni_packet_tx: builds the expected flit sequence of every packet
// from the flit-format rules and compares it with what crosses the RTS/DCTS
// boundary, under fixed, stalled and randomized flow control.
module tb_ni_packet_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cur_addr;
  logic       busy;
  logic       len_err;

  ni_packet_tx_if #(.DATA_WIDTH(32), .AXIS(4)) bus ();

  ni_packet_tx #(.DATA_WIDTH(32), .AXIS(4), .PID_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .cur_addr (cur_addr),
    .bus      (bus),
    .busy     (busy),
    .len_err  (len_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [31:0] exp_q[$];
  logic [27:0] word_q[$];
  int          pid_model = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          pkt_xfers = 0;
  int          first_xfer_cyc = 0;
  int          last_xfer_cyc = 0;
  int          len_err_cnt = 0;
  int          rts_seen = 0;
  int          pkt_count = 0;
  bit          req_acc = 0;
  bit          lat_check = 0;
  bit          hold_prev = 0;
  logic [31:0] tx_prev = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // A flit is its type, 28 bits of content and an even-parity bit.
  function automatic logic [31:0] flit(input logic [2:0] ty, input logic [27:0] body);
    logic [31:0] f;
    f    = {ty, body, 1'b0};
    f[0] = ^f[31:1];
    return f;
  endfunction

  // Observe one cycle at the falling edge, away from the register updates.
  task automatic sample_cycle();
    logic [31:0] e;
    cyc++;
    if (hold_prev) begin
      check("hold_tx", bus.TX, tx_prev);
      check("hold_rts", 32'(bus.RTS), 32'd1);
    end
    if (bus.RTS && !bus.DCTS) check("pl_ready_stall", 32'(bus.pl_ready), 32'd0);
    if (bus.RTS && bus.DCTS) begin
      check("flit_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("flit", bus.TX, e);
        if (pkt_xfers == 0) begin
          first_xfer_cyc = cyc;
          if (lat_check) check("hdr_latency", 32'(cyc - acc_cyc), 32'd2);
        end
        last_xfer_cyc = cyc;
        pkt_xfers++;
      end
    end
    if (bus.pl_valid && bus.pl_ready && word_q.size() > 0) void'(word_q.pop_front());
    if (bus.req_valid && bus.req_ready) begin
      req_acc = 1'b1;
      acc_cyc = cyc;
    end
    if (len_err) len_err_cnt++;
    if (bus.RTS) rts_seen++;
    hold_prev = bus.RTS && !bus.DCTS;
    tx_prev   = bus.TX;
  endtask

  // mode 0: DCTS always high; 1: random DCTS and payload bubbles;
  // 2: DCTS low for 5 cycles while the first body flit is offered.
  // abort_at > 0 stops driving after that many flits have transferred.
  task automatic run_packet(input logic [3:0] dst, input int len, input int mode,
                            input bit seq_words, input int abort_at);
    logic [27:0] w;
    int          budget;
    int          cycles;
    int          stall_cnt;
    exp_q.push_back(flit(3'b001, {12'(len + 1), dst, cur_addr, 8'(pid_model)}));
    for (int i = 0; i < len; i++) begin
      w = seq_words ? 28'(i + 1) : 28'($urandom);
      word_q.push_back(w);
      exp_q.push_back(flit((i == len - 1) ? 3'b100 : 3'b010, w));
    end
    req_acc     = 1'b0;
    pkt_xfers   = 0;
    lat_check   = (mode != 1);
    stall_cnt   = 0;
    budget      = len * 10 + 60;
    cycles      = 0;
    bus.req_dst = dst;
    bus.req_len = 12'(len);
    while (cycles < budget) begin
      if (req_acc && word_q.size() == 0 && exp_q.size() == 0 && !busy) break;
      if (abort_at > 0 && pkt_xfers >= abort_at) break;
      bus.req_valid = !req_acc;
      bus.pl_valid  = (word_q.size() > 0) && (mode != 1 || $urandom_range(0, 3) != 0);
      bus.pl_data   = (word_q.size() > 0) ? word_q[0] : 28'd0;
      case (mode)
        0: bus.DCTS = 1'b1;
        1: bus.DCTS = ($urandom_range(0, 3) != 0);
        default: begin
          if (bus.RTS && bus.TX[31:29] == 3'b010 && stall_cnt < 5) begin
            bus.DCTS = 1'b0;
            stall_cnt++;
          end else begin
            bus.DCTS = 1'b1;
          end
        end
      endcase
      @(negedge clk);
      sample_cycle();
      @(posedge clk);
      #1;
      cycles++;
    end
    bus.req_valid = 1'b0;
    bus.pl_valid  = 1'b0;
    bus.DCTS      = 1'b1;
    if (abort_at == 0) begin
      check("pkt_done", 32'(cycles < budget), 32'd1);
      $display("pkt %0d dst=%0h src=%0h len=%0d pid=%0d cycles=%0d",
               pkt_count, dst, cur_addr, len, pid_model, cycles);
      pid_model = (pid_model + 1) % 256;
      pkt_count++;
    end
    if (mode == 2) check("stall_cycles", 32'(stall_cnt), 32'd5);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b0;
    cur_addr      = 4'h1;
    bus.req_valid = 1'b0;
    bus.req_dst   = '0;
    bus.req_len   = '0;
    bus.pl_valid  = 1'b0;
    bus.pl_data   = '0;
    bus.DCTS      = 1'b1;

    // Outputs while held in reset
    #12;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_pl_ready", 32'(bus.pl_ready), 32'd0);
    check("rst_rts", 32'(bus.RTS), 32'd0);
    check("rst_tx", bus.TX, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_len_err", 32'(len_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("req_ready_after_rst", 32'(bus.req_ready), 32'd1);

    // Basic packet: header + body, body, tail back to back
    run_packet(4'h2, 3, 0, 1'b1, 0);
    check("back_to_back_len3", 32'(last_xfer_cyc - first_xfer_cyc), 32'd3);

    // Same packet with the first body flit stalled for 5 cycles
    run_packet(4'h2, 3, 2, 1'b1, 0);

    // Single-word packet: header then tail only
    run_packet(4'h5, 1, 0, 1'b0, 0);
    check("back_to_back_len1", 32'(last_xfer_cyc - first_xfer_cyc), 32'd1);
    check("len1_busy_low", 32'(busy), 32'd0);

    // Zero-length request is consumed and flagged, nothing is sent
    len_err_cnt   = 0;
    rts_seen      = 0;
    req_acc       = 1'b0;
    bus.req_dst   = 4'h3;
    bus.req_len   = 12'd0;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sample_cycle();
      check("len0_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      if (req_acc) bus.req_valid = 1'b0;
    end
    bus.req_valid = 1'b0;
    check("len0_accepted", 32'(req_acc), 32'd1);
    check("len0_err_pulses", 32'(len_err_cnt), 32'd1);
    check("len0_rts", 32'(rts_seen), 32'd0);
    $display("len0 request len_err_pulses=%0d", len_err_cnt);

    // Longest legal packet
    run_packet(4'hA, 4094, 0, 1'b0, 0);

    // Many short random packets with random flow control; pid wraps 255 -> 0
    for (int p = 0; p < 257; p++) begin
      cur_addr = 4'($urandom);
      run_packet(4'($urandom), $urandom_range(1, 5), 1, 1'b0, 0);
    end

    // Reset in the middle of a body: output clears at once, pid restarts
    cur_addr = 4'h1;
    run_packet(4'h3, 6, 0, 1'b0, 2);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_rts", 32'(bus.RTS), 32'd0);
    check("midrst_tx", bus.TX, 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    check("midrst_pl_ready", 32'(bus.pl_ready), 32'd0);
    exp_q.delete();
    word_q.delete();
    pid_model = 0;
    hold_prev = 1'b0;
    $display("reset asserted mid-body");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("req_ready_after_midrst", 32'(bus.req_ready), 32'd1);
    run_packet(4'h4, 2, 0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
